mem_write_dmux: RTL and testbench
=================================

# mem_write_dmux

Registered write demultiplexer for the Hack memory map: accepts one CPU data-memory write per cycle on a valid/ready input and routes it to exactly one sink, either RAM or SCREEN, through a one-entry output holding stage. Writes to the keyboard address or above are consumed, dropped and flagged as errors. The block sits between the CPU's `addressM`/`outM`/`writeM` path and the memory sinks, and is the routing counterpart of the 2:1 `mux` primitive.

## Interface
- `DATA_W`, 16, write data width
- `SCREEN_BASE`, 16384, first SCREEN address
- `KBD_ADDR`, 24576, keyboard address; every address ≥ this is illegal for writes
- `clk` input 1: single clock; all state updates on the rising edge
- `reset` input 1: asynchronous, active-high; clears all state immediately
- `in_valid` input 1: write request present
- `in_ready` output 1: request accepted on a cycle where `in_valid && in_ready`
- `in_addr` input 15: Hack word address
- `in_data` input DATA_W: write data
- `ram_valid` output 1: RAM write pending
- `ram_ready` input 1: RAM sink accepts the write
- `ram_addr` output 14: `in_addr[13:0]`
- `ram_data` output DATA_W: write data
- `scr_valid` output 1: SCREEN write pending
- `scr_ready` input 1: SCREEN sink accepts the write
- `scr_addr` output 13: `in_addr - SCREEN_BASE`, 13 bits
- `scr_data` output DATA_W: write data
- `err_pulse` output 1: one-cycle pulse, illegal write consumed
- `err_count` output 8: saturating illegal-write count (see Configuration)

## Operation
- State machine with two states.
  - IDLE: holding register is empty.
  - HOLD: holding register contains one decoded write, tagged with a target of RAM or SCR.
- Decode of `in_addr`:
  - `< SCREEN_BASE` → RAM.
  - `SCREEN_BASE` to `KBD_ADDR-1` → SCR.
  - `≥ KBD_ADDR` → ILLEGAL.
- Output valid signals:
  - `ram_valid = HOLD && target==RAM`.
  - `scr_valid = HOLD && target==SCR`.
  - At most one of them is high in any cycle.
- The held entry drains on a cycle where `sel_ready` (the ready input of the held target) is high.
- `in_ready = IDLE || sel_ready`. This is a combinational path from the sink ready inputs to `in_ready`; there is no path from `in_valid` to `in_ready`.
- Acceptance of a legal write: register addr, data and target, then go to HOLD on the next edge. This applies from IDLE, and from HOLD in the same cycle the current entry drains (back-to-back writes, no bubble).
- Acceptance of an ILLEGAL write:
  - Nothing is loaded.
  - `err_pulse` is high in the next cycle.
  - `err_count` increments.
  - State becomes IDLE if the current entry drained, otherwise it stays unchanged.
- HOLD without drain:
  - addr, data and target are stable.
  - `in_ready` is low.
  - Output valid stays high until the handshake; it never deasserts early.
- Address and data outputs are registered; their values are don't-care while the corresponding valid is low.

## Timing
- Reset values:
  - State IDLE.
  - `ram_valid = scr_valid = 0`.
  - `err_pulse = 0`.
  - `err_count = 0`.
  - Data and address registers are 0.
  - `in_ready = 1` (combinational, following IDLE).
- Latency: a write accepted at edge N has its sink valid high from edge N+1.
- Throughput: one write per cycle while sinks hold ready high.
- Simultaneous drain and accept: the new entry replaces the old one at the same edge. The old write completes at that edge and the new write is visible after it.
- Back-to-back writes to different targets: the valid signal moves from one sink to the other with no idle cycle.
- Reset mid-operation:
  - Any held write is discarded.
  - The valid outputs drop asynchronously.
  - `err_count` clears.
- `err_count` saturates at 255; further illegal writes still pulse `err_pulse`.

## Configuration
- `MEM_WRITE_DMUX_ERRCNT_EN`
  - Defined: `err_count` is an 8-bit saturating register as specified.
  - Undefined: no counter register; `err_count` is tied to 0. `err_pulse` and all routing behaviour are unchanged.

## Test plan
- Reset:
  - Stimulus: assert `reset` mid-cycle while HOLD has a RAM write pending.
  - Required: `ram_valid` drops to 0 before the next edge and `in_ready` = 1. After release, no stale write appears.
- RAM routing:
  - Stimulus: addr=0x0005, data=0x1234, both sinks ready.
  - Required: one cycle later `ram_valid` = 1, `ram_addr` = 5, `ram_data` = 0x1234 for exactly one cycle, and `scr_valid` = 0 throughout.
- SCREEN routing and backpressure:
  - Stimulus: addr=16384+100, data=0xFFFF, `scr_ready` = 0 for 3 cycles.
  - Required: `scr_valid` = 1 and `scr_addr` = 100, held stable for 3 cycles. `in_ready` = 0 during the stall. The write completes on the first cycle `scr_ready` = 1.
- Back-to-back writes:
  - Stimulus: RAM 0x3FFF, then SCREEN 24575, then RAM 0, on consecutive cycles with sinks always ready.
  - Required: three consecutive output cycles with `ram_addr` = 0x3FFF, then `scr_addr` = 8191, then `ram_addr` = 0. `in_ready` stays 1 throughout.
- Illegal writes:
  - Stimulus: write to 24576, then to 32767.
  - Required: both are accepted with no sink valid. `err_pulse` fires once per write. `err_count` = 2, or 0 with the macro undefined.
- Error counter saturation:
  - Stimulus: 300 illegal writes.
  - Required: `err_count` = 255 and `err_pulse` fires on all 300.

Source files
------------

// File: rtl/mem_write_dmux.sv
// mem_write_dmux: registered write demultiplexer for the Hack memory map.
// Routes one CPU data-memory write per cycle to RAM or SCREEN through a
// one-entry holding stage. Writes at or above the keyboard address are
// consumed, dropped and reported through err_pulse / err_count.
//
// Optional feature macro: MEM_WRITE_DMUX_ERRCNT_EN
//   defined   : err_count is an 8-bit saturating illegal-write counter
//   undefined : no counter register, err_count tied to 0
//
// Ports:
//   clk, reset                      clock, async active-high reset
//   in_valid/in_ready               write request handshake
//   in_addr[14:0], in_data          Hack word address and write data
//   ram_valid/ram_ready             RAM sink handshake
//   ram_addr[13:0], ram_data        RAM write address/data
//   scr_valid/scr_ready             SCREEN sink handshake
//   scr_addr[12:0], scr_data        SCREEN offset address/data
//   err_pulse                       one-cycle pulse per dropped illegal write
//   err_count[7:0]                  saturating illegal-write count
module mem_write_dmux #(
    parameter int unsigned DATA_W      = 16,
    parameter int unsigned SCREEN_BASE = 16384,
    parameter int unsigned KBD_ADDR    = 24576
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [14:0]       in_addr,
    input  logic [DATA_W-1:0] in_data,
    output logic              ram_valid,
    input  logic              ram_ready,
    output logic [13:0]       ram_addr,
    output logic [DATA_W-1:0] ram_data,
    output logic              scr_valid,
    input  logic              scr_ready,
    output logic [12:0]       scr_addr,
    output logic [DATA_W-1:0] scr_data,
    output logic              err_pulse,
    output logic [7:0]        err_count
);

    localparam int unsigned ADDR_W = 15;
    localparam int unsigned RAM_AW = 14;
    localparam int unsigned SCR_AW = 13;
    localparam int unsigned CNT_W  = 8;

    typedef enum logic {S_IDLE = 1'b0, S_HOLD = 1'b1} state_t;
    typedef enum logic {T_RAM = 1'b0, T_SCR = 1'b1} target_t;

    state_t              r_state;
    state_t              w_state_nxt;
    target_t             r_target;
    logic [RAM_AW-1:0]   r_ram_addr;
    logic [SCR_AW-1:0]   r_scr_addr;
    logic [DATA_W-1:0]   r_data;
    logic                r_err_pulse;

    logic w_sel_ready;
    logic w_drain;
    logic w_in_ready;
    logic w_accept;
    logic w_illegal;
    logic w_is_scr;
    logic w_load;
    logic w_err;

    // Handshake and address decode; in_ready depends only on sink readies
    always_comb begin
        w_sel_ready = (r_target == T_SCR) ? scr_ready : ram_ready;
        w_drain     = (r_state == S_HOLD) && w_sel_ready;
        w_in_ready  = (r_state == S_IDLE) || w_sel_ready;
        w_accept    = in_valid && w_in_ready;
        w_illegal   = (in_addr >= ADDR_W'(KBD_ADDR));
        w_is_scr    = (in_addr >= ADDR_W'(SCREEN_BASE));
        w_load      = w_accept && !w_illegal;
        w_err       = w_accept && w_illegal;
    end

    // Next state: a legal accept (re)fills the holder, a bare drain empties it
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_load) w_state_nxt = S_HOLD;
            end
            S_HOLD: begin
                if (w_load)       w_state_nxt = S_HOLD;
                else if (w_drain) w_state_nxt = S_IDLE;
            end
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_state <= S_IDLE;
        else       r_state <= w_state_nxt;
    end

    // Holding register: loaded only on legal accepts, otherwise stable
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_target   <= T_RAM;
            r_ram_addr <= '0;
            r_scr_addr <= '0;
            r_data     <= '0;
        end else if (w_load) begin
            r_target   <= w_is_scr ? T_SCR : T_RAM;
            r_ram_addr <= in_addr[RAM_AW-1:0];
            r_scr_addr <= SCR_AW'(in_addr - ADDR_W'(SCREEN_BASE));
            r_data     <= in_data;
        end
    end

    // Error pulse for each consumed illegal write
    always_ff @(posedge clk or posedge reset) begin
        if (reset) r_err_pulse <= 1'b0;
        else       r_err_pulse <= w_err;
    end

`ifdef MEM_WRITE_DMUX_ERRCNT_EN
    logic [CNT_W-1:0] r_err_count;

    // Saturating illegal-write counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_err_count <= '0;
        end else if (w_err && (r_err_count != {CNT_W{1'b1}})) begin
            r_err_count <= r_err_count + CNT_W'(1);
        end
    end

    assign err_count = r_err_count;
`else
    assign err_count = CNT_W'(0);
`endif

    assign in_ready  = w_in_ready;
    assign ram_valid = (r_state == S_HOLD) && (r_target == T_RAM);
    assign scr_valid = (r_state == S_HOLD) && (r_target == T_SCR);
    assign ram_addr  = r_ram_addr;
    assign scr_addr  = r_scr_addr;
    assign ram_data  = r_data;
    assign scr_data  = r_data;
    assign err_pulse = r_err_pulse;

endmodule

// File: tb/tb_mem_write_dmux.sv
// Testbench for mem_write_dmux: directed scenarios plus a randomized run
// checked against a per-sink FIFO scoreboard built from the address map.
module tb_mem_write_dmux;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [14:0] in_addr;
    logic [15:0] in_data;
    logic        ram_valid;
    logic        ram_ready;
    logic [13:0] ram_addr;
    logic [15:0] ram_data;
    logic        scr_valid;
    logic        scr_ready;
    logic [12:0] scr_addr;
    logic [15:0] scr_data;
    logic        err_pulse;
    logic [7:0]  err_count;

    int total = 0;
    int bad   = 0;
    int n_illegal = 0;   // illegal writes accepted since last reset

`ifdef MEM_WRITE_DMUX_ERRCNT_EN
    localparam bit CNT_EN = 1'b1;
`else
    localparam bit CNT_EN = 1'b0;
`endif

    mem_write_dmux dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_addr(in_addr), .in_data(in_data),
        .ram_valid(ram_valid), .ram_ready(ram_ready),
        .ram_addr(ram_addr), .ram_data(ram_data),
        .scr_valid(scr_valid), .scr_ready(scr_ready),
        .scr_addr(scr_addr), .scr_data(scr_data),
        .err_pulse(err_pulse), .err_count(err_count)
    );

    always #5 clk = ~clk;

    function automatic logic [7:0] exp_count(input int n);
        if (!CNT_EN) return 8'd0;
        return (n > 255) ? 8'd255 : 8'(n);
    endfunction

    task automatic drive(input logic v, input int a, input logic [15:0] d,
                         input logic rr, input logic sr);
        in_valid  = v;
        in_addr   = 15'(a);
        in_data   = d;
        ram_ready = rr;
        scr_ready = sr;
    endtask

    task automatic test_reset;
        reset = 1'b1;
        drive(1'b0, 0, 16'h0, 1'b1, 1'b1);
        #1;
        total++; if (ram_valid !== 1'b0 || scr_valid !== 1'b0) begin bad++;
            $display("FAIL reset_valid: ram=%b scr=%b want 0 0", ram_valid, scr_valid); end
        total++; if (in_ready !== 1'b1) begin bad++;
            $display("FAIL reset_in_ready: got %b want 1", in_ready); end
        total++; if (err_pulse !== 1'b0 || err_count !== 8'd0) begin bad++;
            $display("FAIL reset_err: pulse=%b count=%0d want 0 0", err_pulse, err_count); end
        total++; if (ram_addr !== 14'd0 || scr_addr !== 13'd0 || ram_data !== 16'd0) begin bad++;
            $display("FAIL reset_regs: ram_addr=%h scr_addr=%h data=%h want 0", ram_addr, scr_addr, ram_data); end
        @(negedge clk); reset = 1'b0;
        drive(1'b1, 30000, 16'h0, 1'b1, 1'b1);
        n_illegal++;
        @(negedge clk);
        drive(1'b1, 16'h0123, 16'hBEEF, 1'b0, 1'b1);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        total++; if (ram_valid !== 1'b1 || ram_addr !== 14'h0123 || err_count !== exp_count(n_illegal)) begin bad++;
            $display("FAIL reset_pre: ram_valid=%b addr=%h count=%0d want 1 0123 %0d",
                     ram_valid, ram_addr, err_count, exp_count(n_illegal)); end
        #1 reset = 1'b1;
        n_illegal = 0;
        #1;
        total++; if (ram_valid !== 1'b0 || in_ready !== 1'b1 || err_count !== 8'd0) begin bad++;
            $display("FAIL reset_async: ram_valid=%b in_ready=%b count=%0d want 0 1 0",
                     ram_valid, in_ready, err_count); end
        @(negedge clk); reset = 1'b0; ram_ready = 1'b1;
        @(negedge clk); #1;
        total++; if (ram_valid !== 1'b0 || scr_valid !== 1'b0) begin bad++;
            $display("FAIL reset_stale: ram=%b scr=%b want 0 0", ram_valid, scr_valid); end
    endtask

    task automatic test_ram_routing;
        @(negedge clk); drive(1'b1, 5, 16'h1234, 1'b1, 1'b1);
        #1;
        total++; if (in_ready !== 1'b1) begin bad++;
            $display("FAIL ram_in_ready: got %b want 1", in_ready); end
        @(negedge clk); in_valid = 1'b0; #1;
        total++; if (ram_valid !== 1'b1 || ram_addr !== 14'd5 || ram_data !== 16'h1234 || scr_valid !== 1'b0) begin bad++;
            $display("FAIL ram_route: valid=%b addr=%0d data=%h scr=%b want 1 5 1234 0",
                     ram_valid, ram_addr, ram_data, scr_valid); end
        @(negedge clk); #1;
        total++; if (ram_valid !== 1'b0 || scr_valid !== 1'b0) begin bad++;
            $display("FAIL ram_once: ram=%b scr=%b want 0 0", ram_valid, scr_valid); end
    endtask

    task automatic test_screen_backpressure;
        @(negedge clk); drive(1'b1, 16384 + 100, 16'hFFFF, 1'b1, 1'b0);
        @(negedge clk); drive(1'b1, 7, 16'h0A0A, 1'b1, 1'b0);
        for (int i = 0; i < 3; i++) begin
            #1;
            total++; if (scr_valid !== 1'b1 || scr_addr !== 13'd100 || scr_data !== 16'hFFFF
                         || in_ready !== 1'b0 || ram_valid !== 1'b0) begin bad++;
                $display("FAIL scr_stall%0d: valid=%b addr=%0d data=%h in_ready=%b ram=%b want 1 100 ffff 0 0",
                         i, scr_valid, scr_addr, scr_data, in_ready, ram_valid); end
            @(negedge clk);
        end
        scr_ready = 1'b1; #1;
        total++; if (in_ready !== 1'b1 || scr_valid !== 1'b1) begin bad++;
            $display("FAIL scr_release: in_ready=%b scr_valid=%b want 1 1", in_ready, scr_valid); end
        @(negedge clk); in_valid = 1'b0; #1;
        total++; if (scr_valid !== 1'b0 || ram_valid !== 1'b1 || ram_addr !== 14'd7 || ram_data !== 16'h0A0A) begin bad++;
            $display("FAIL scr_done: scr=%b ram=%b addr=%0d data=%h want 0 1 7 0a0a",
                     scr_valid, ram_valid, ram_addr, ram_data); end
        @(negedge clk); #1;
        total++; if (ram_valid !== 1'b0) begin bad++;
            $display("FAIL scr_after: ram_valid=%b want 0", ram_valid); end
    endtask

    task automatic test_back_to_back;
        @(negedge clk); drive(1'b1, 16'h3FFF, 16'h1111, 1'b1, 1'b1); #1;
        total++; if (in_ready !== 1'b1) begin bad++;
            $display("FAIL b2b_rdy0: got %b want 1", in_ready); end
        @(negedge clk); drive(1'b1, 24575, 16'h2222, 1'b1, 1'b1); #1;
        total++; if (ram_valid !== 1'b1 || ram_addr !== 14'h3FFF || scr_valid !== 1'b0 || in_ready !== 1'b1) begin bad++;
            $display("FAIL b2b_1: ram=%b addr=%h scr=%b rdy=%b want 1 3fff 0 1", ram_valid, ram_addr, scr_valid, in_ready); end
        @(negedge clk); drive(1'b1, 0, 16'h3333, 1'b1, 1'b1); #1;
        total++; if (scr_valid !== 1'b1 || scr_addr !== 13'd8191 || scr_data !== 16'h2222
                     || ram_valid !== 1'b0 || in_ready !== 1'b1) begin bad++;
            $display("FAIL b2b_2: scr=%b addr=%0d data=%h ram=%b rdy=%b want 1 8191 2222 0 1",
                     scr_valid, scr_addr, scr_data, ram_valid, in_ready); end
        @(negedge clk); in_valid = 1'b0; #1;
        total++; if (ram_valid !== 1'b1 || ram_addr !== 14'd0 || ram_data !== 16'h3333 || scr_valid !== 1'b0) begin bad++;
            $display("FAIL b2b_3: ram=%b addr=%h data=%h scr=%b want 1 0 3333 0", ram_valid, ram_addr, ram_data, scr_valid); end
        @(negedge clk); #1;
    endtask

    task automatic test_illegal;
        @(negedge clk); drive(1'b1, 24576, 16'h5555, 1'b1, 1'b1); #1;
        total++; if (in_ready !== 1'b1) begin bad++;
            $display("FAIL ill_rdy: got %b want 1", in_ready); end
        n_illegal++;
        @(negedge clk); drive(1'b1, 32767, 16'h6666, 1'b1, 1'b1); #1;
        n_illegal++;
        total++; if (err_pulse !== 1'b1 || ram_valid !== 1'b0 || scr_valid !== 1'b0 || in_ready !== 1'b1) begin bad++;
            $display("FAIL ill_1: pulse=%b ram=%b scr=%b rdy=%b want 1 0 0 1", err_pulse, ram_valid, scr_valid, in_ready); end
        @(negedge clk); in_valid = 1'b0; #1;
        total++; if (err_pulse !== 1'b1 || ram_valid !== 1'b0 || scr_valid !== 1'b0 || err_count !== exp_count(2)) begin bad++;
            $display("FAIL ill_2: pulse=%b ram=%b scr=%b count=%0d want 1 0 0 %0d",
                     err_pulse, ram_valid, scr_valid, err_count, exp_count(2)); end
        @(negedge clk); #1;
        total++; if (err_pulse !== 1'b0) begin bad++;
            $display("FAIL ill_end: pulse=%b want 0", err_pulse); end
    endtask

    task automatic test_saturation;
        int pulses = 0;
        for (int i = 0; i <= 300; i++) begin
            @(negedge clk); #1;
            if (i > 0 && err_pulse === 1'b1) pulses++;
            if (i < 300) begin
                drive(1'b1, int'($urandom_range(32767, 24576)), 16'($urandom), 1'($urandom), 1'($urandom));
                n_illegal++;
            end else begin
                in_valid = 1'b0;
            end
        end
        total++; if (pulses != 300) begin bad++;
            $display("FAIL sat_pulses: got %0d want 300", pulses); end
        total++; if (err_count !== exp_count(n_illegal)) begin bad++;
            $display("FAIL sat_count: got %0d want %0d", err_count, exp_count(n_illegal)); end
        @(negedge clk); #1;
    endtask

    task automatic test_random;
        logic [29:0] ram_q[$];
        logic [28:0] scr_q[$];
        logic [29:0] er;
        logic [28:0] es;
        logic        prev_err = 1'b0;
        logic        exp_rdy;
        int          a;
        int          nbad = 0;
        for (int cyc = 0; cyc < 2000; cyc++) begin
            @(negedge clk);
            case ($urandom_range(0, 4))
                0, 1:    a = int'($urandom_range(16383, 0));
                2, 3:    a = int'($urandom_range(24575, 16384));
                default: a = int'($urandom_range(32767, 24576));
            endcase
            if (cyc >= 1996) drive(1'b0, a, 16'($urandom), 1'b1, 1'b1);
            else drive(($urandom_range(0, 3) != 0), a, 16'($urandom),
                       ($urandom_range(0, 3) != 0), ($urandom_range(0, 3) != 0));
            #1;
            exp_rdy = !(ram_valid || scr_valid) || (ram_valid && ram_ready) || (scr_valid && scr_ready);
            total++; if (in_ready !== exp_rdy || (ram_valid && scr_valid) || err_pulse !== prev_err) begin
                bad++; nbad++;
                if (nbad < 10) $display("FAIL rnd_ctl c%0d: rdy=%b/%b ram=%b scr=%b pulse=%b/%b",
                                        cyc, in_ready, exp_rdy, ram_valid, scr_valid, err_pulse, prev_err);
            end
            if (ram_valid === 1'b1 && ram_ready) begin
                er = (ram_q.size() != 0) ? ram_q.pop_front() : 30'h3FFFFFFF;
                total++; if ({ram_addr, ram_data} !== er) begin bad++; nbad++;
                    if (nbad < 10) $display("FAIL rnd_ram c%0d: got %h want %h", cyc, {ram_addr, ram_data}, er); end
            end
            if (scr_valid === 1'b1 && scr_ready) begin
                es = (scr_q.size() != 0) ? scr_q.pop_front() : 29'h1FFFFFFF;
                total++; if ({scr_addr, scr_data} !== es) begin bad++; nbad++;
                    if (nbad < 10) $display("FAIL rnd_scr c%0d: got %h want %h", cyc, {scr_addr, scr_data}, es); end
            end
            prev_err = 1'b0;
            if (in_valid && exp_rdy) begin
                if (a < 16384)      ram_q.push_back({14'(a), in_data});
                else if (a < 24576) scr_q.push_back({13'(a - 16384), in_data});
                else begin prev_err = 1'b1; n_illegal++; end
            end
        end
        total++; if (ram_q.size() != 0 || scr_q.size() != 0) begin bad++;
            $display("FAIL rnd_drain: ram_q=%0d scr_q=%0d want 0 0", ram_q.size(), scr_q.size()); end
        total++; if (err_count !== exp_count(n_illegal)) begin bad++;
            $display("FAIL rnd_count: got %0d want %0d", err_count, exp_count(n_illegal)); end
    endtask

    initial begin
        test_reset();
        test_ram_routing();
        test_screen_backpressure();
        test_back_to_back();
        test_illegal();
        test_saturation();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
